// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit common-anode 7-segment scan driver with a per-digit dwell prescaler.
// Optional macro GHOST_BLANK_EN: when defined, the anodes are held off for BLANK cycles at each dwell start.
module seg_scan_driver #(
  parameter int DIV   = 1000,
  parameter int BLANK = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] digit_in,
  output logic [2:0] sel,
  output logic       mux_en_n,
  output logic [6:0] seg,
  output logic [7:0] an,
  output logic       frame_done
);

  localparam int PW = $clog2(DIV);

  logic [PW-1:0] presc;
  logic          tick;
  logic          an_ok;
  logic [7:0]    an_nxt;
  logic [6:0]    seg_nxt;

  assign tick = run && (presc == PW'(DIV - 1));

`ifdef GHOST_BLANK_EN
  assign an_ok = (presc >= PW'(BLANK));
`else
  logic [31:0] blank_unused;
  assign blank_unused = BLANK;
  assign an_ok = 1'b1;
`endif

  // Active-low hex decode; anything that is not a clean 0..F (e.g. X from a disabled mux) stays dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      4'hF: s = 7'h0E;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  // A disabled mux drives X, so the segments are forced dark while it is off.
  always_comb begin
    seg_nxt = 7'h7F;
    an_nxt  = 8'hFF;
    if (run && !mux_en_n) seg_nxt = decode(digit_in);
    if (run && an_ok)     an_nxt  = ~(8'd1 << sel);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc      <= '0;
      sel        <= 3'd0;
      mux_en_n   <= 1'b1;
      seg        <= 7'h7F;
      an         <= 8'hFF;
      frame_done <= 1'b0;
    end else begin
      mux_en_n   <= ~run;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= tick && (sel == 3'd7);
      if (!run) begin
        presc <= '0;
      end else if (tick) begin
        presc <= '0;
        sel   <= sel + 3'd1;
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: arithmetic scan model compared every cycle, plus literal pins.
// Honours GHOST_BLANK_EN the same way the design does.
module tb_seg_scan_driver;

  localparam int DIV   = 4;
  localparam int BLANK = 1;
`ifdef GHOST_BLANK_EN
  localparam bit GHOST = 1'b1;
`else
  localparam bit GHOST = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       run = 1'b0;
  logic [3:0] digit_in;
  logic [2:0] sel;
  logic       mux_en_n;
  logic [6:0] seg;
  logic [7:0] an;
  logic       frame_done;

  logic [3:0] mem [8];
  logic [6:0] dec_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] lit_seg [8] = '{7'h12, 7'h78, 7'h19, 7'h40, 7'h30, 7'h40, 7'h10, 7'h79};

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // upstream 8:1 mux: drives X when disabled
  assign digit_in = mux_en_n ? 4'bxxxx : mem[sel];

  seg_scan_driver #(.DIV(DIV), .BLANK(BLANK)) dut (
    .clk(clk), .rst(rst), .run(run), .digit_in(digit_in),
    .sel(sel), .mux_en_n(mux_en_n), .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the scan position is base digit plus elapsed running cycles / DIV.
  int         run_cycles = 0;
  int         base_sel   = 0;
  logic [2:0] e_sel      = 3'd0;
  logic       e_mux_en_n = 1'b1;
  logic [6:0] e_seg      = 7'h7F;
  logic [7:0] e_an       = 8'hFF;
  logic       e_fd       = 1'b0;

  always @(posedge clk) begin : model
    int cs;
    int cp;
    if (rst) begin
      run_cycles = 0;
      base_sel   = 0;
      e_mux_en_n = 1'b1;
      e_seg      = 7'h7F;
      e_an       = 8'hFF;
      e_fd       = 1'b0;
    end else begin
      cs    = (base_sel + run_cycles / DIV) % 8;
      cp    = run_cycles % DIV;
      e_seg = (run && !e_mux_en_n) ? dec_tab[mem[cs]] : 7'h7F;
      e_an  = (run && (!GHOST || cp >= BLANK)) ? ~(8'd1 << cs) : 8'hFF;
      e_fd  = run && (cp == DIV - 1) && (cs == 7);
      e_mux_en_n = !run;
      if (run) run_cycles++;
      else begin
        base_sel   = cs;
        run_cycles = 0;
      end
    end
    e_sel = 3'((base_sel + run_cycles / DIV) % 8);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", 32'(sel), 32'(e_sel));
      check("mux_en_n", 32'(mux_en_n), 32'(e_mux_en_n));
      check("seg", 32'(seg), 32'(e_seg));
      check("an", 32'(an), 32'(e_an));
      check("frame_done", 32'(frame_done), 32'(e_fd));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int fd_cnt;
    int blank_cnt;
    int kk;
    int w;

    mem = '{4'd5, 4'd7, 4'd4, 4'd0, 4'd3, 4'd0, 4'd9, 4'd1};
    rst = 1'b1;
    run = 1'b1;

    // reset held with run high
    for (int i = 0; i < 3; i++) begin
      step();
      chk_en = 1'b1;
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_mux_en_n", 32'(mux_en_n), 32'd1);
      check("rst_seg", 32'(seg), 32'h7F);
      check("rst_an", 32'(an), 32'hFF);
      check("rst_fd", 32'(frame_done), 32'd0);
    end
    rst = 1'b0;

    // full frame with the fixed digit pattern
    repeat (8) step();
    fd_cnt = 0;
    blank_cnt = 0;
    for (int c = 0; c < 32; c++) begin
      step();
      if (frame_done) fd_cnt++;
      if (an == 8'hFF) blank_cnt++;
      else begin
        kk = -1;
        for (int k = 0; k < 8; k++) if (an == ~(8'd1 << k)) kk = k;
        if (kk < 0) check("an_onehot", 32'(an), 32'hFE);
        else check("frame_seg_lit", 32'(seg), 32'(lit_seg[kk]));
      end
    end
    check("frame_done_per_frame", 32'(fd_cnt), 32'd1);
    check("blank_cycles_per_frame", 32'(blank_cnt), GHOST ? 32'd8 : 32'd0);

    // pause mid-dwell at sel=3, presc=2
    w = 0;
    while (!(e_sel == 3'd3 && (run_cycles % DIV) == 2) && w < 64) begin
      step();
      w++;
    end
    check("wait_pause_point", 32'(w < 64), 32'd1);
    run = 1'b0;
    step();
    check("pause_an", 32'(an), 32'hFF);
    check("pause_seg", 32'(seg), 32'h7F);
    check("pause_mux_en_n", 32'(mux_en_n), 32'd1);
    check("pause_sel", 32'(sel), 32'd3);
    repeat (3) step();
    check("pause_sel_held", 32'(sel), 32'd3);
    run = 1'b1;
    step();
    check("resume_first_an", 32'(an), GHOST ? 32'hFF : 32'hF7);
    repeat (2) step();
    check("resume_sel_still_3", 32'(sel), 32'd3);
    step();
    check("resume_sel_4", 32'(sel), 32'd4);

    // wrap 7 -> 0
    w = 0;
    while (e_sel != 3'd7 && w < 64) begin
      step();
      w++;
    end
    check("wait_sel7", 32'(w < 64), 32'd1);
    fd_cnt = 0;
    for (int c = 0; c < DIV + 2; c++) begin
      step();
      if (frame_done) fd_cnt++;
    end
    check("wrap_fd_single", 32'(fd_cnt), 32'd1);

    // reset at sel=5
    w = 0;
    while (e_sel != 3'd5 && w < 64) begin
      step();
      w++;
    end
    check("wait_sel5", 32'(w < 64), 32'd1);
    rst = 1'b1;
    step();
    check("midrst_sel", 32'(sel), 32'd0);
    check("midrst_an", 32'(an), 32'hFF);
    rst = 1'b0;

    // every hex digit through the decoder
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) mem[i] = 4'(i + 8 * f);
      repeat (36) step();
    end

    // randomized run/rst/digit traffic
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < 8; i++) mem[i] = 4'($urandom_range(0, 15));
      for (int c = 0; c < 40; c++) begin
        run = ($urandom_range(0, 9) != 0);
        rst = ($urandom_range(0, 99) == 0);
        step();
      end
    end
    rst = 1'b0;
    run = 1'b0;
    repeat (2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
